// File: rtl/band_mixer.sv
// band_mixer: three-band synthesis mixer.
// Each accepted low/mid/high triple is scaled by its per-band gain on one
// shared multiplier (one band per cycle), summed, then rounded half-up and
// saturated back to a signed AUDIO_DEPTH-bit sample.
//
// Ports:
//   clk, reset               clock (rising edge), synchronous active-high reset
//   sample_valid/ready       triple handshake; ready only in IDLE
//   low/mid/high_band        signed band samples
//   gain_wr_en/sel/wr_data   staging gain write (sel 0=low 1=mid 2=high 3=none)
//   audio_out                signed mixed sample, held between updates
//   out_valid                one-cycle pulse when audio_out updates
//   clip                     one-cycle pulse with out_valid when clamped
module band_mixer #(
    parameter int unsigned AUDIO_DEPTH = 16,
    parameter int unsigned GAIN_WIDTH  = 8,
    parameter int unsigned GAIN_FRAC   = 6,
    parameter int unsigned ACC_WIDTH   = 28
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic signed [AUDIO_DEPTH-1:0] low_band,
    input  logic signed [AUDIO_DEPTH-1:0] mid_band,
    input  logic signed [AUDIO_DEPTH-1:0] high_band,
    input  logic                          gain_wr_en,
    input  logic [1:0]                    gain_sel,
    input  logic [GAIN_WIDTH-1:0]         gain_wr_data,
    output logic signed [AUDIO_DEPTH-1:0] audio_out,
    output logic                          out_valid,
    output logic                          clip
);

    localparam int unsigned PROD_W = AUDIO_DEPTH + GAIN_WIDTH + 1;
    localparam int unsigned RND_W  = ACC_WIDTH - GAIN_FRAC;

    localparam logic [GAIN_WIDTH-1:0]        UNITY = GAIN_WIDTH'(1 << GAIN_FRAC);
    localparam logic signed [ACC_WIDTH-1:0]  HALF  = ACC_WIDTH'(1 << (GAIN_FRAC - 1));
    localparam logic signed [RND_W-1:0]      MAX_V = RND_W'((1 << (AUDIO_DEPTH - 1)) - 1);
    localparam logic signed [RND_W-1:0]      MIN_V = ~MAX_V;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_L = 3'd1,
        MUL_M = 3'd2,
        MUL_H = 3'd3,
        SAT   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [GAIN_WIDTH-1:0]         stg_low, stg_mid, stg_high;
    logic [GAIN_WIDTH-1:0]         act_low, act_mid, act_high;
    logic signed [AUDIO_DEPTH-1:0] band_low, band_mid, band_high;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic signed [AUDIO_DEPTH-1:0] mul_band;
    logic [GAIN_WIDTH-1:0]         mul_gain;
    logic signed [GAIN_WIDTH:0]    gain_ext;
    logic signed [PROD_W-1:0]      product;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc_rnd;
    logic signed [RND_W-1:0]       rounded;
    logic signed [AUDIO_DEPTH-1:0] sat_val;
    logic                          sat_clip;

    // State register; ready is registered from the next state so it is high exactly in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
        end else begin
            state        <= next_state;
            sample_ready <= (next_state == IDLE);
        end
    end

    // Next-state sequencing: one multiply per band, then a saturate cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_valid) next_state = MUL_L;
            MUL_L:   next_state = MUL_M;
            MUL_M:   next_state = MUL_H;
            MUL_H:   next_state = SAT;
            SAT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shared multiplier operand select; gain is zero-extended so it multiplies as signed.
    always_comb begin
        mul_band = band_low;
        mul_gain = act_low;
        case (state)
            MUL_M: begin
                mul_band = band_mid;
                mul_gain = act_mid;
            end
            MUL_H: begin
                mul_band = band_high;
                mul_gain = act_high;
            end
            default: ;
        endcase
        gain_ext = {1'b0, mul_gain};
        product  = PROD_W'(mul_band) * PROD_W'(gain_ext);
        prod_ext = ACC_WIDTH'(product);
    end

    // Round half up, arithmetic shift, clamp to the output range.
    always_comb begin
        acc_rnd  = acc + HALF;
        rounded  = RND_W'(acc_rnd >>> GAIN_FRAC);
        sat_val  = AUDIO_DEPTH'(rounded);
        sat_clip = 1'b0;
        if (rounded > MAX_V) begin
            sat_val  = AUDIO_DEPTH'(MAX_V);
            sat_clip = 1'b1;
        end else if (rounded < MIN_V) begin
            sat_val  = AUDIO_DEPTH'(MIN_V);
            sat_clip = 1'b1;
        end
    end

    // Datapath: gain staging, capture/snapshot on accept, accumulate, output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_low   <= UNITY;
            stg_mid   <= UNITY;
            stg_high  <= UNITY;
            act_low   <= UNITY;
            act_mid   <= UNITY;
            act_high  <= UNITY;
            band_low  <= '0;
            band_mid  <= '0;
            band_high <= '0;
            acc       <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;

            if (gain_wr_en) begin
                case (gain_sel)
                    2'd0:    stg_low  <= gain_wr_data;
                    2'd1:    stg_mid  <= gain_wr_data;
                    2'd2:    stg_high <= gain_wr_data;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    // Snapshot reads staging before any same-cycle write lands.
                    if (sample_valid) begin
                        band_low  <= low_band;
                        band_mid  <= mid_band;
                        band_high <= high_band;
                        act_low   <= stg_low;
                        act_mid   <= stg_mid;
                        act_high  <= stg_high;
                    end
                end
                MUL_L:   acc <= prod_ext;
                MUL_M:   acc <= acc + prod_ext;
                MUL_H:   acc <= acc + prod_ext;
                SAT: begin
                    audio_out <= sat_val;
                    out_valid <= 1'b1;
                    clip      <= sat_clip;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: directed, scoreboard-checked bench for band_mixer.
module tb_band_mixer;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] low_band, mid_band, high_band;
    logic               gain_wr_en;
    logic [1:0]         gain_sel;
    logic [7:0]         gain_wr_data;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic               clip;

    band_mixer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .low_band     (low_band),
        .mid_band     (mid_band),
        .high_band    (high_band),
        .gain_wr_en   (gain_wr_en),
        .gain_sel     (gain_sel),
        .gain_wr_data (gain_wr_data),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint audio;
        logic   clip;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     pulses = 0;
    int     pulse_cyc[$];
    longint g_low = 64, g_mid = 64, g_high = 64;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint l, input longint m, input longint h);
        exp_t   e;
        longint s;
        longint r;
        s = l * g_low + m * g_mid + h * g_high;
        r = (s + 32) >>> 6;
        e.clip = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.clip = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.clip = 1'b1;
        end
        e.audio = r;
        return e;
    endfunction

    // Output monitor: every out_valid pulse pops one expected result.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("audio_out", longint'(audio_out), e.audio);
                check("clip", longint'(clip), longint'(e.clip));
            end
        end
    end

    function automatic void model_write(input logic [1:0] sel, input longint data);
        case (sel)
            2'd0: g_low  = data;
            2'd1: g_mid  = data;
            2'd2: g_high = data;
            default: ;
        endcase
    endfunction

    // Called just after a rising edge; write is sampled at the next edge.
    task automatic write_gain(input logic [1:0] sel, input logic [7:0] data);
        gain_wr_en   = 1'b1;
        gain_sel     = sel;
        gain_wr_data = data;
        @(posedge clk);
        #1;
        gain_wr_en = 1'b0;
        model_write(sel, longint'(data));
    endtask

    // Wait for ready, present a triple (optionally with a same-cycle gain write), return after the accept edge.
    task automatic send(input longint l, input longint m, input longint h,
                        input logic wr, input logic [1:0] sel, input logic [7:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        sample_valid = 1'b1;
        low_band     = 16'(l);
        mid_band     = 16'(m);
        high_band    = 16'(h);
        gain_wr_en   = wr;
        gain_sel     = sel;
        gain_wr_data = data;
        sb.push_back(model(l, m, h));
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        gain_wr_en   = 1'b0;
        if (wr) model_write(sel, longint'(data));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, longint'(sb.size()), 0);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        low_band     = '0;
        mid_band     = '0;
        high_band    = '0;
        gain_wr_en   = 1'b0;
        gain_sel     = 2'd0;
        gain_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_audio_out", longint'(audio_out), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_clip", longint'(clip), 0);
        check("rst_ready", longint'(sample_ready), 1);

        // Unity gains; latency: out_valid visible only after the fourth edge past acceptance.
        send(1000, 2000, 3000, 1'b0, 2'd0, 8'd0);
        check("busy_ready", longint'(sample_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        check("early_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("latency_out_valid", longint'(out_valid), 1);
        check("latency_audio", longint'(audio_out), 6000);
        drain("drain_unity");
        check("hold_audio", longint'(audio_out), 6000);

        // Mixed gains: 0 + 200 + 200.
        write_gain(2'd0, 8'd0);
        write_gain(2'd1, 8'd128);
        write_gain(2'd2, 8'd32);
        send(5000, 100, 400, 1'b0, 2'd0, 8'd0);
        drain("drain_mixed");
        check("mixed_audio", longint'(audio_out), 400);

        // Rounding at half: 1 -> 1, -1 -> 0, -3 -> -1.
        write_gain(2'd0, 8'd32);
        write_gain(2'd1, 8'd0);
        write_gain(2'd2, 8'd0);
        send(1, 0, 0, 1'b0, 2'd0, 8'd0);
        send(-1, 0, 0, 1'b0, 2'd0, 8'd0);
        send(-3, 0, 0, 1'b0, 2'd0, 8'd0);
        drain("drain_round");
        check("round_last", longint'(audio_out), -1);

        // Saturation both ways.
        write_gain(2'd0, 8'd255);
        write_gain(2'd1, 8'd255);
        write_gain(2'd2, 8'd255);
        send(32767, 32767, 32767, 1'b0, 2'd0, 8'd0);
        send(-32768, -32768, -32768, 1'b0, 2'd0, 8'd0);
        drain("drain_sat");

        // Gain timing: write during MUL_M of A, then a write in B's acceptance cycle.
        write_gain(2'd0, 8'd64);
        write_gain(2'd1, 8'd0);
        write_gain(2'd2, 8'd0);
        send(100, 0, 0, 1'b0, 2'd0, 8'd0);
        @(posedge clk);
        #1;
        write_gain(2'd0, 8'd128);
        drain("drain_gain_a");
        check("gain_a", longint'(audio_out), 100);
        send(100, 0, 0, 1'b1, 2'd0, 8'd32);
        drain("drain_gain_b");
        check("gain_b", longint'(audio_out), 200);
        send(100, 0, 0, 1'b0, 2'd0, 8'd0);
        drain("drain_gain_c");
        check("gain_c", longint'(audio_out), 50);

        // gain_sel=3 writes nothing.
        send(100, 0, 0, 1'b1, 2'd3, 8'd200);
        drain("drain_sel3");
        check("sel3_audio", longint'(audio_out), 50);

        // Reset while in MUL_H aborts the sample and restores unity gains.
        write_gain(2'd1, 8'd10);
        send(300, 300, 300, 1'b0, 2'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        g_low  = 64;
        g_mid  = 64;
        g_high = 64;
        check("abort_audio", longint'(audio_out), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_ready", longint'(sample_ready), 1);
        repeat (8) @(posedge clk);
        #1;

        // Four back-to-back triples with valid held high.
        pulses = 0;
        pulse_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!sample_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!sample_ready) check("b2b_ready_timeout", 0, 1);
            sample_valid = 1'b1;
            low_band     = 16'(100 * (i + 1));
            mid_band     = 16'(-7 * i);
            high_band    = 16'(3);
            sb.push_back(model(longint'(100 * (i + 1)), longint'(-7 * i), 3));
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        drain("drain_b2b");
        repeat (10) @(posedge clk);
        #1;
        check("b2b_pulses", longint'(pulses), 4);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("b2b_period", longint'(pulse_cyc[i] - pulse_cyc[i-1]), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
